// File: rtl/alu_seqdp_if.sv
// Operand/result bundle for the sequential ALU datapath slice.
// Master drives the request and operands; slave returns the result, status and flags.
interface alu_seqdp_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_h;
  logic [2:0]       op_h;
  logic [1:0]       dsize_h;
  logic [WIDTH-1:0] a_h;
  logic [WIDTH-1:0] b_h;
  logic             busy_h;
  logic             done_h;
  logic [WIDTH-1:0] wbus_h_out;
  logic [WIDTH-1:0] q_h_out;
  logic             n_h;
  logic             z_h;
  logic             v_h;
  logic             c_h;
  logic             dz_h;

  modport master (
    output start_h, op_h, dsize_h, a_h, b_h,
    input  busy_h, done_h, wbus_h_out, q_h_out, n_h, z_h, v_h, c_h, dz_h
  );

  modport slave (
    input  start_h, op_h, dsize_h, a_h, b_h,
    output busy_h, done_h, wbus_h_out, q_h_out, n_h, z_h, v_h, c_h, dz_h
  );
endinterface

// File: rtl/alu_seqdp.sv
// ALU datapath slice: single-cycle sized ALU ops plus an iterative
// shift-add multiplier and restoring divider sharing one A/Q register pair.
module alu_seqdp #(
  parameter int unsigned WIDTH = 32
) (
  input logic        qd_clk_l,
  input logic        reset_l,
  alu_seqdp_if.slave bus
);
  localparam int unsigned CNTW = $clog2(WIDTH);

  localparam logic [2:0] OpNop = 3'b000;
  localparam logic [2:0] OpAdd = 3'b001;
  localparam logic [2:0] OpSub = 3'b010;
  localparam logic [2:0] OpAnd = 3'b011;
  localparam logic [2:0] OpOr  = 3'b100;
  localparam logic [2:0] OpXor = 3'b101;
  localparam logic [2:0] OpMul = 3'b110;
  localparam logic [2:0] OpDiv = 3'b111;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             n_q, n_d, z_q, z_d, v_q, v_d, c_q, c_d, dz_q, dz_d;

  // Single-cycle ALU result and flags at the active operand size
  logic [WIDTH-1:0] msk, am, bm, alu_res;
  logic [WIDTH:0]   raw;
  logic             a_msb, b_msb, r_msb, carry, alu_v, alu_c;

  always_comb begin
    unique case (bus.dsize_h)
      2'b00:   msk = WIDTH'(8'hFF);
      2'b01:   msk = WIDTH'(16'hFFFF);
      2'b10:   msk = WIDTH'(32'hFFFF_FFFF);
      default: msk = '1;
    endcase
    am = bus.a_h & msk;
    bm = bus.b_h & msk;
    case (bus.op_h)
      OpAdd:   raw = {1'b0, am} + {1'b0, bm};
      OpSub:   raw = {1'b0, am} - {1'b0, bm};
      OpAnd:   raw = {1'b0, am & bm};
      OpOr:    raw = {1'b0, am | bm};
      OpXor:   raw = {1'b0, am ^ bm};
      default: raw = '0;
    endcase
    alu_res = raw[WIDTH-1:0] & msk;
    // Operands are zero above the size, so raw[S] is the carry/borrow out of bit S-1
    unique case (bus.dsize_h)
      2'b00: begin
        a_msb = am[7];  b_msb = bm[7];  r_msb = raw[7];  carry = raw[8];
      end
      2'b01: begin
        a_msb = am[15]; b_msb = bm[15]; r_msb = raw[15]; carry = raw[16];
      end
      2'b10: begin
        a_msb = am[31]; b_msb = bm[31]; r_msb = raw[31]; carry = raw[32];
      end
      default: begin
        a_msb = am[WIDTH-1]; b_msb = bm[WIDTH-1]; r_msb = raw[WIDTH-1]; carry = raw[WIDTH];
      end
    endcase
    alu_v = 1'b0;
    alu_c = 1'b0;
    if (bus.op_h == OpAdd) begin
      alu_v = (a_msb == b_msb) && (r_msb != a_msb);
      alu_c = carry;
    end else if (bus.op_h == OpSub) begin
      alu_v = (a_msb != b_msb) && (r_msb != a_msb);
      alu_c = carry;
    end
  end

  // One multiply or divide step on {A,Q}; B holds multiplicand or divisor
  logic [WIDTH:0]   mul_sum, div_sh;
  logic [WIDTH-1:0] div_trial, step_a, step_q;
  logic             div_ge;

  always_comb begin
    mul_sum   = {1'b0, a_q} + (q_q[0] ? {1'b0, b_q} : '0);
    div_sh    = {a_q, q_q[WIDTH-1]};
    div_ge    = (div_sh >= {1'b0, b_q});
    div_trial = div_sh[WIDTH-1:0] - b_q;
    if (div_q) begin
      step_a = div_ge ? div_trial : div_sh[WIDTH-1:0];
      step_q = {q_q[WIDTH-2:0], div_ge};
    end else begin
      step_a = mul_sum[WIDTH:1];
      step_q = {mul_sum[0], q_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    n_d     = n_q;
    z_d     = z_q;
    v_d     = v_q;
    c_d     = c_q;
    dz_d    = dz_q;
    case (state_q)
      StRun: begin
        a_d   = step_a;
        q_d   = step_q;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == '0) begin
          state_d = StDone;
          c_d     = 1'b0;
          if (div_q) begin
            n_d = step_q[WIDTH-1];
            z_d = (step_q == '0);
            v_d = 1'b0;
          end else begin
            n_d = step_a[WIDTH-1];
            z_d = (step_a == '0) && (step_q == '0);
            v_d = (step_a != '0);
          end
        end
      end
      default: begin
        if (state_q == StDone) state_d = StIdle;
        if (bus.start_h && (bus.op_h != OpNop)) begin
          dz_d = 1'b0;
          c_d  = 1'b0;
          v_d  = 1'b0;
          case (bus.op_h)
            OpMul: begin
              b_d     = bus.a_h;
              q_d     = bus.b_h;
              a_d     = '0;
              cnt_d   = CNTW'(WIDTH - 1);
              div_d   = 1'b0;
              state_d = StRun;
            end
            OpDiv: begin
              if (bus.b_h == '0) begin
                q_d     = '1;
                a_d     = bus.a_h;
                dz_d    = 1'b1;
                v_d     = 1'b1;
                n_d     = 1'b1;
                z_d     = 1'b0;
                state_d = StDone;
              end else begin
                b_d     = bus.b_h;
                q_d     = bus.a_h;
                a_d     = '0;
                cnt_d   = CNTW'(WIDTH - 1);
                div_d   = 1'b1;
                state_d = StRun;
              end
            end
            default: begin
              q_d     = alu_res;
              a_d     = '0;
              n_d     = r_msb;
              z_d     = (alu_res == '0);
              v_d     = alu_v;
              c_d     = alu_c;
              state_d = StDone;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge qd_clk_l) begin
    if (!reset_l) begin
      state_q <= StIdle;
      a_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      c_q     <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      n_q     <= n_d;
      z_q     <= z_d;
      v_q     <= v_d;
      c_q     <= c_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy_h     = (state_q == StRun);
  assign bus.done_h     = (state_q == StDone);
  assign bus.wbus_h_out = q_q;
  assign bus.q_h_out    = a_q;
  assign bus.n_h        = n_q;
  assign bus.z_h        = z_q;
  assign bus.v_h        = v_q;
  assign bus.c_h        = c_q;
  assign bus.dz_h       = dz_q;
endmodule

// File: tb/tb_alu_seqdp.sv
// Bench for alu_seqdp: 32- and 64-bit instances, directed vectors checked against
// an arithmetic reference model through a scoreboard plus literal expectations.
module tb_alu_seqdp;
  logic clk = 1'b0;
  logic reset_l;
  always #5 clk = ~clk;

  alu_seqdp_if #(.WIDTH(32)) bus32 ();
  alu_seqdp_if #(.WIDTH(64)) bus64 ();

  alu_seqdp #(.WIDTH(32)) dut32 (.qd_clk_l(clk), .reset_l(reset_l), .bus(bus32));
  alu_seqdp #(.WIDTH(64)) dut64 (.qd_clk_l(clk), .reset_l(reset_l), .bus(bus64));

  typedef struct packed {
    logic [63:0] w;
    logic [63:0] q;
    logic [5:0]  f;  // {busy, n, z, v, c, dz}
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t exp32_q[$];
  exp_t exp64_q[$];
  exp_t cmp_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic signed [127:0] sx(input logic [63:0] x, input int unsigned s);
    logic signed [127:0] r;
    r = $signed({64'd0, x});
    if (x[s-1]) r = r - (128'sd1 <<< s);
    return r;
  endfunction

  // Reference: results from plain integer arithmetic at the given width/size
  function automatic exp_t model(input int unsigned width, input logic [2:0] op,
                                 input logic [1:0] ds, input logic [63:0] a,
                                 input logic [63:0] b);
    exp_t e;
    int unsigned s;
    logic [63:0] fm, m, am, bm;
    logic [127:0] u;
    logic signed [127:0] sv, lim;
    logic n, z, v, c, dz;
    e  = '0;
    n  = 1'b0; z = 1'b0; v = 1'b0; c = 1'b0; dz = 1'b0;
    fm = (width == 64) ? '1 : ((64'd1 << width) - 64'd1);
    s  = (ds == 2'd0) ? 32'd8 : (ds == 2'd1) ? 32'd16 : (ds == 2'd2) ? 32'd32 : width;
    m  = (s == 64) ? '1 : ((64'd1 << s) - 64'd1);
    am = a & m;
    bm = b & m;
    case (op)
      3'd1, 3'd2: begin
        if (op == 3'd1) begin
          u  = {64'd0, am} + {64'd0, bm};
          sv = sx(am, s) + sx(bm, s);
          c  = (u >= (128'd1 << s));
        end else begin
          u  = {64'd0, am} - {64'd0, bm};
          sv = sx(am, s) - sx(bm, s);
          c  = (am < bm);
        end
        lim = 128'sd1 <<< (s - 1);
        v   = (sv >= lim) || (sv < -lim);
        e.w = u[63:0] & m;
      end
      3'd3: e.w = am & bm;
      3'd4: e.w = am | bm;
      3'd5: e.w = am ^ bm;
      3'd6: begin
        u   = {64'd0, a} * {64'd0, b};
        e.w = u[63:0] & fm;
        e.q = 64'(u >> width) & fm;
        n   = e.q[width-1];
        z   = (u == '0);
        v   = (e.q != '0);
      end
      3'd7: begin
        if (b == '0) begin
          e.w = fm; e.q = a; n = 1'b1; v = 1'b1; dz = 1'b1;
        end else begin
          e.w = a / b;
          e.q = a % b;
          n   = e.w[width-1];
          z   = (e.w == '0);
        end
      end
      default: ;
    endcase
    if (op >= 3'd1 && op <= 3'd5) begin
      n = e.w[s-1];
      z = (e.w == '0);
    end
    e.f = {1'b0, n, z, v, c, dz};
    return e;
  endfunction

  // Scoreboard compare: every done strobe must match the oldest expected result
  always @(negedge clk) begin
    if (reset_l) begin
      if (bus32.done_h) begin
        if (exp32_q.size() == 0) begin
          chk("unexpected_done32", 64'd1, 64'd0);
        end else begin
          cmp_e = exp32_q.pop_front();
          chk("sb32_wbus", 64'(bus32.wbus_h_out), cmp_e.w);
          chk("sb32_q", 64'(bus32.q_h_out), cmp_e.q);
          chk("sb32_flags", 64'({bus32.busy_h, bus32.n_h, bus32.z_h, bus32.v_h, bus32.c_h,
                                 bus32.dz_h}), 64'(cmp_e.f));
        end
      end
      if (bus64.done_h) begin
        if (exp64_q.size() == 0) begin
          chk("unexpected_done64", 64'd1, 64'd0);
        end else begin
          cmp_e = exp64_q.pop_front();
          chk("sb64_wbus", bus64.wbus_h_out, cmp_e.w);
          chk("sb64_q", bus64.q_h_out, cmp_e.q);
          chk("sb64_flags", 64'({bus64.busy_h, bus64.n_h, bus64.z_h, bus64.v_h, bus64.c_h,
                                 bus64.dz_h}), 64'(cmp_e.f));
        end
      end
    end
  end

  task automatic issue32(input logic [2:0] op, input logic [1:0] ds, input logic [31:0] a,
                         input logic [31:0] b);
    bus32.start_h = 1'b1;
    bus32.op_h    = op;
    bus32.dsize_h = ds;
    bus32.a_h     = a;
    bus32.b_h     = b;
    if (op != 3'd0) exp32_q.push_back(model(32, op, ds, {32'd0, a}, {32'd0, b}));
    @(negedge clk);
    bus32.start_h = 1'b0;
  endtask

  task automatic issue64(input logic [2:0] op, input logic [1:0] ds, input logic [63:0] a,
                         input logic [63:0] b);
    bus64.start_h = 1'b1;
    bus64.op_h    = op;
    bus64.dsize_h = ds;
    bus64.a_h     = a;
    bus64.b_h     = b;
    if (op != 3'd0) exp64_q.push_back(model(64, op, ds, a, b));
    @(negedge clk);
    bus64.start_h = 1'b0;
  endtask

  // Latency counts edges after the accepting edge; optional ignored start pulse mid-run
  task automatic wait_done32(input string name, input int exp_lat, input int exp_busy,
                             input int pulse_at);
    int lat = 0;
    int busy = 0;
    while (!bus32.done_h && lat < 300) begin
      if (bus32.busy_h) busy++;
      bus32.start_h = (lat == pulse_at);
      if (lat == pulse_at) begin
        bus32.op_h = 3'd1; bus32.a_h = 32'd1; bus32.b_h = 32'd1;
      end
      @(negedge clk);
      lat++;
    end
    bus32.start_h = 1'b0;
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({name, "_busy"}, 64'(busy), 64'(exp_busy));
  endtask

  task automatic wait_done64(input string name, input int exp_lat, input int exp_busy);
    int lat = 0;
    int busy = 0;
    while (!bus64.done_h && lat < 300) begin
      if (bus64.busy_h) busy++;
      @(negedge clk);
      lat++;
    end
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({name, "_busy"}, 64'(busy), 64'(exp_busy));
  endtask

  // f = {n, z, v, c, dz}
  task automatic lit32(input string name, input logic [31:0] w, input logic [31:0] q,
                       input logic [4:0] f);
    chk({name, "_w"}, 64'(bus32.wbus_h_out), 64'(w));
    chk({name, "_q"}, 64'(bus32.q_h_out), 64'(q));
    chk({name, "_f"}, 64'({bus32.n_h, bus32.z_h, bus32.v_h, bus32.c_h, bus32.dz_h}), 64'(f));
  endtask

  task automatic lit64(input string name, input logic [63:0] w, input logic [63:0] q,
                       input logic [4:0] f);
    chk({name, "_w"}, bus64.wbus_h_out, w);
    chk({name, "_q"}, bus64.q_h_out, q);
    chk({name, "_f"}, 64'({bus64.n_h, bus64.z_h, bus64.v_h, bus64.c_h, bus64.dz_h}), 64'(f));
  endtask

  task automatic chk_zero32(input string name);
    chk({name, "_data"}, {bus32.wbus_h_out, bus32.q_h_out}, 64'd0);
    chk({name, "_ctl"}, 64'({bus32.busy_h, bus32.done_h, bus32.n_h, bus32.z_h, bus32.v_h,
                             bus32.c_h, bus32.dz_h}), 64'd0);
  endtask

  task automatic chk_zero64(input string name);
    chk({name, "_w"}, bus64.wbus_h_out, 64'd0);
    chk({name, "_q"}, bus64.q_h_out, 64'd0);
    chk({name, "_ctl"}, 64'({bus64.busy_h, bus64.done_h, bus64.n_h, bus64.z_h, bus64.v_h,
                             bus64.c_h, bus64.dz_h}), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_l = 1'b0;
    bus32.start_h = 1'b0; bus32.op_h = '0; bus32.dsize_h = '0; bus32.a_h = '0; bus32.b_h = '0;
    bus64.start_h = 1'b0; bus64.op_h = '0; bus64.dsize_h = '0; bus64.a_h = '0; bus64.b_h = '0;
    repeat (3) @(negedge clk);
    chk_zero32("reset32");
    chk_zero64("reset64");
    reset_l = 1'b1;
    @(negedge clk);

    issue32(3'd1, 2'b00, 32'h7F, 32'h01);
    wait_done32("add_b", 0, 0, -1);
    lit32("add_b", 32'h80, 32'h0, 5'b10100);
    issue32(3'd2, 2'b10, 32'h0, 32'h1);
    wait_done32("sub_l", 0, 0, -1);
    lit32("sub_l", 32'hFFFF_FFFF, 32'h0, 5'b10010);
    issue32(3'd3, 2'b10, 32'hF0, 32'h0F);  // issued in the DONE cycle of the SUB
    wait_done32("and_b2b", 0, 0, -1);
    lit32("and_b2b", 32'h0, 32'h0, 5'b01000);
    issue32(3'd1, 2'b01, 32'hFFFF, 32'h1);
    wait_done32("add_w", 0, 0, -1);
    lit32("add_w", 32'h0, 32'h0, 5'b01010);
    issue32(3'd2, 2'b00, 32'h80, 32'h1);
    wait_done32("sub_b", 0, 0, -1);
    lit32("sub_b", 32'h7F, 32'h0, 5'b00100);
    issue32(3'd1, 2'b00, 32'h1234_5678, 32'h1111_1111);
    wait_done32("add_b_hi", 0, 0, -1);
    lit32("add_b_hi", 32'h89, 32'h0, 5'b10100);
    issue32(3'd4, 2'b10, 32'hF0F0_0000, 32'h0F0F_0001);
    wait_done32("or_l", 0, 0, -1);
    issue32(3'd5, 2'b11, 32'hAAAA_5555, 32'hAAAA_5555);
    wait_done32("xor_f", 0, 0, -1);
    issue32(3'd2, 2'b11, 32'h5, 32'h7);
    wait_done32("sub_f", 0, 0, -1);

    issue32(3'd6, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done32("mul_max", 32, 32, 5);
    lit32("mul_max", 32'h1, 32'hFFFF_FFFE, 5'b10100);
    issue32(3'd6, 2'b01, 32'd12345, 32'd6789);
    wait_done32("mul_mid", 32, 32, -1);
    issue32(3'd6, 2'b10, 32'h0, 32'h5);
    wait_done32("mul_zero", 32, 32, -1);

    issue32(3'd7, 2'b00, 32'd100, 32'd7);
    wait_done32("div", 32, 32, -1);
    lit32("div", 32'd14, 32'd2, 5'b00000);
    issue32(3'd7, 2'b00, 32'd5, 32'd0);
    wait_done32("div0", 0, 0, -1);
    lit32("div0", 32'hFFFF_FFFF, 32'd5, 5'b10101);
    issue32(3'd7, 2'b00, 32'd7, 32'd100);
    wait_done32("div_small", 32, 32, -1);
    issue32(3'd7, 2'b00, 32'h8000_0000, 32'd1);
    wait_done32("div_one", 32, 32, -1);

    issue32(3'd0, 2'b10, 32'd1, 32'd1);
    @(negedge clk);
    chk("nop_no_done", 64'(bus32.done_h), 64'd0);
    chk("nop_hold", 64'(bus32.wbus_h_out), 64'h8000_0000);

    issue32(3'd6, 2'b10, 32'hFFFF_FFFF, 32'd3);
    repeat (9) @(negedge clk);
    reset_l = 1'b0;
    exp32_q.delete();
    @(negedge clk);
    chk_zero32("rst_mid");
    reset_l = 1'b1;
    @(negedge clk);
    chk_zero32("rst_after");
    issue32(3'd1, 2'b10, 32'd1, 32'd1);
    wait_done32("add_post_rst", 0, 0, -1);
    lit32("add_post_rst", 32'd2, 32'd0, 5'b00000);

    issue64(3'd6, 2'b00, 64'h1_0000_0000, 64'h1_0000_0000);
    wait_done64("mul64", 64, 64);
    lit64("mul64", 64'h0, 64'h1, 5'b00100);
    issue64(3'd1, 2'b11, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
    wait_done64("add64", 0, 0);
    lit64("add64", 64'h8000_0000_0000_0000, 64'h0, 5'b10100);
    issue64(3'd7, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0001);
    wait_done64("div64", 64, 64);
    issue64(3'd2, 2'b10, 64'hFFFF_FFFF_0000_0000, 64'h1);
    wait_done64("sub64_l", 0, 0);
    @(negedge clk);

    chk("sb32_drained", 64'(exp32_q.size()), 64'd0);
    chk("sb64_drained", 64'(exp64_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
